// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared types, default 640x480@60 timing constants and helpers
//            for computing the total line and frame lengths.
// Contents : coord_t      - 11-bit pixel coordinate
//            *_DEF        - default porch / sync / active widths
//            calc_h_total - pixels per line including blanking
//            calc_v_total - lines per frame including blanking
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

    typedef logic [10:0] coord_t;

    // Largest total that still fits in coord_t.
    localparam int COORD_MAX = 2047;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    function automatic int calc_h_total(input int active, input int fp,
                                        input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int calc_v_total(input int active, input int fp,
                                        input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage : vga_pkg
`default_nettype wire

// File: rtl/vga_pix_div.sv
`default_nettype none
// ============================================================================
// Module   : vga_pix_div
// Purpose  : Divide-by-two pixel clock-enable. The enable is low out of
//            reset, goes high after the first rising edge, and then toggles,
//            so the first enabled edge is the second one after release.
// Ports    : clk      - system clock
//            rst_n    - asynchronous active-low reset
//            pix_tick - registered clock-enable, high every second clk
// Revision : 1.0 - initial release
// ============================================================================
module vga_pix_div (
    input  logic clk,
    input  logic rst_n,
    output logic pix_tick
);

    logic div_q;
    logic div_d;

    always_comb begin
        div_d = ~div_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= 1'b0;
        end else begin
            div_q <= div_d;
        end
    end

    assign pix_tick = div_q;

endmodule : vga_pix_div
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing
// Purpose  : VGA raster timing generator. Walks a pixel/line counter pair
//            over the full total raster and produces registered coordinates,
//            video_on, sync strobes and line/frame start pulses.
// Ports    : clk         - system clock, all state changes on rising edge
//            rst_n       - asynchronous active-low reset
//            pix_tick    - pixel clock-enable (1 every clk, or every second
//                          clk when VGA_PIXDIV_EN is defined)
//            pix_x/pix_y - current column / row, unclamped
//            video_on    - inside the visible area
//            hsync/vsync - sync strobes, asserted level = SYNC_POL
//            line_start  - one-clk pulse when pix_x becomes 0
//            frame_start - one-clk pulse when pix_x and pix_y become 0
// Macro    : VGA_PIXDIV_EN - enables the divide-by-two pixel enable
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic   clk,
    input  logic   rst_n,
    output logic   pix_tick,
    output coord_t pix_x,
    output coord_t pix_y,
    output logic   video_on,
    output logic   hsync,
    output logic   vsync,
    output logic   line_start,
    output logic   frame_start
);

    localparam int H_TOTAL = calc_h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calc_v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS    = coord_t'(H_ACTIVE);
    localparam coord_t V_VIS    = coord_t'(V_ACTIVE);
    localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    generate
        if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_bad_total
            $error("vga_timing: H_TOTAL/V_TOTAL exceed 2047");
        end
        if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
            V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_bad_width
            $error("vga_timing: timing widths must be non-zero");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pixel clock-enable source
    // ------------------------------------------------------------------
`ifdef VGA_PIXDIV_EN
    vga_pix_div u_pix_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .pix_tick (pix_tick)
    );
`else
    assign pix_tick = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Counters and registered outputs
    // ------------------------------------------------------------------
    coord_t h_cnt_q, h_cnt_d;
    coord_t v_cnt_q, v_cnt_d;
    coord_t pix_x_q, pix_x_d;
    coord_t pix_y_q, pix_y_d;
    logic   video_on_q, video_on_d;
    logic   hsync_q, hsync_d;
    logic   vsync_q, vsync_d;
    logic   line_start_q, line_start_d;
    logic   frame_start_q, frame_start_d;

    coord_t h_next;
    coord_t v_next;

    always_comb begin
        // Next raster position if this edge is a pixel edge.
        h_next = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + coord_t'(1);
        v_next = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            v_next = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + coord_t'(1);
        end

        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        video_on_d    = video_on_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        // Every output is decoded from the same next counter value and
        // registered in the same stage, so they never skew against each other.
        if (pix_tick) begin
            h_cnt_d       = h_next;
            v_cnt_d       = v_next;
            pix_x_d       = h_next;
            pix_y_d       = v_next;
            video_on_d    = (h_next < H_VIS) && (v_next < V_VIS);
            hsync_d       = (h_next >= HS_START && h_next < HS_END) ? SYNC_POL : ~SYNC_POL;
            vsync_d       = (v_next >= VS_START && v_next < VS_END) ? SYNC_POL : ~SYNC_POL;
            line_start_d  = (h_next == '0);
            frame_start_d = (h_next == '0) && (v_next == '0);
        end
    end

    // Counters park at the last position so the first pixel edge after
    // reset lands exactly on (0,0) and fires both start pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q       <= H_LAST;
            v_cnt_q       <= V_LAST;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            video_on_q    <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            video_on_q    <= video_on_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign video_on    = video_on_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule : vga_timing
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing
// Purpose  : Self-checking bench for vga_timing. Instance A uses default
//            640x480 timing with SYNC_POL=0; instance B uses a small raster
//            with SYNC_POL=1 so whole frames fit in a short run. A raster
//            model derives every output from the count of pixel ticks since
//            reset release. Works with or without VGA_PIXDIV_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing;

    // Instance B small raster
    localparam int B_HA = 40, B_HFP = 4, B_HS = 8, B_HBP = 6;
    localparam int B_VA = 30, B_VFP = 2, B_VS = 3, B_VBP = 4;
    localparam int B_HT = B_HA + B_HFP + B_HS + B_HBP;   // 58
    localparam int B_VT = B_VA + B_VFP + B_VS + B_VBP;   // 39

`ifdef VGA_PIXDIV_EN
    localparam int CLK_PER_TICK = 2;
`else
    localparam int CLK_PER_TICK = 1;
`endif

    logic clk = 1'b0;
    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;

    always #5 clk = ~clk;

    logic        tick_a, von_a, hs_a, vs_a, ls_a, fs_a;
    logic [10:0] x_a, y_a;
    logic        tick_b, von_b, hs_b, vs_b, ls_b, fs_b;
    logic [10:0] x_b, y_b;

    vga_timing u_dut_a (
        .clk         (clk),
        .rst_n       (rst_a_n),
        .pix_tick    (tick_a),
        .pix_x       (x_a),
        .pix_y       (y_a),
        .video_on    (von_a),
        .hsync       (hs_a),
        .vsync       (vs_a),
        .line_start  (ls_a),
        .frame_start (fs_a)
    );

    vga_timing #(
        .H_ACTIVE (B_HA), .H_FP (B_HFP), .H_SYNC (B_HS), .H_BP (B_HBP),
        .V_ACTIVE (B_VA), .V_FP (B_VFP), .V_SYNC (B_VS), .V_BP (B_VBP),
        .SYNC_POL (1'b1)
    ) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_b_n),
        .pix_tick    (tick_b),
        .pix_x       (x_b),
        .pix_y       (y_b),
        .video_on    (von_b),
        .hsync       (hs_b),
        .vsync       (vs_b),
        .line_start  (ls_b),
        .frame_start (fs_b)
    );

    logic [27:0] obs_a, obs_b;
    assign obs_a = {tick_a, x_a, y_a, von_a, hs_a, vs_a, ls_a, fs_a};
    assign obs_b = {tick_b, x_b, y_b, von_b, hs_b, vs_b, ls_b, fs_b};

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Raster model: k = pixel ticks since release, e = clk edges since release.
    function automatic logic [27:0] model(input int ha, input int hfp, input int hs, input int hbp,
                                          input int va, input int vfp, input int vs, input int vbp,
                                          input logic pol, input int e, input int k, input bit jt);
        int   ht, vt, n, x, y;
        logic tk, von, hsv, vsv, ls, fs;
`ifdef VGA_PIXDIV_EN
        tk = (e % 2 == 1);
`else
        tk = 1'b1;
`endif
        if (k == 0) return {tk, 11'd0, 11'd0, 1'b0, ~pol, ~pol, 1'b0, 1'b0};
        ht  = ha + hfp + hs + hbp;
        vt  = va + vfp + vs + vbp;
        n   = (k - 1) % (ht * vt);
        x   = n % ht;
        y   = n / ht;
        von = (x < ha) && (y < va);
        hsv = (x >= ha + hfp && x < ha + hfp + hs) ? pol : ~pol;
        vsv = (y >= va + vfp && y < va + vfp + vs) ? pol : ~pol;
        ls  = jt && (x == 0);
        fs  = jt && (n == 0);
        return {tk, 11'(x), 11'(y), von, hsv, vsv, ls, fs};
    endfunction

    int e_a = 0, k_a = 0, e_b = 0, k_b = 0;
    bit jt_a = 0, jt_b = 0;

    function automatic logic [27:0] exp_a();
        return model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, e_a, k_a, jt_a);
    endfunction
    function automatic logic [27:0] exp_b();
        return model(B_HA, B_HFP, B_HS, B_HBP, B_VA, B_VFP, B_VS, B_VBP, 1'b1, e_b, k_b, jt_b);
    endfunction

    // Edge e advances the raster when the enable was high before it.
    function automatic bit tick_edge(input int e);
`ifdef VGA_PIXDIV_EN
        return (e % 2 == 0);
`else
        return 1'b1;
`endif
    endfunction

    // Observed-statistics for the first line (A) and first frame (B)
    bit stats_en = 0;
    int hs_cnt_a = 0, blank_cnt_a = 0, vs_cnt_b = 0;
    int ls_k_a[$], ls_e_a[$], fs_k_b[$];

    task automatic cyc();
        @(posedge clk);
        if (rst_a_n) begin
            e_a++;
            jt_a = tick_edge(e_a);
            if (jt_a) k_a++;
        end else jt_a = 0;
        if (rst_b_n) begin
            e_b++;
            jt_b = tick_edge(e_b);
            if (jt_b) k_b++;
        end else jt_b = 0;
        #1;
        check("rasterA", {4'd0, obs_a}, {4'd0, exp_a()});
        check("rasterB", {4'd0, obs_b}, {4'd0, exp_b()});
        if (stats_en) begin
            if (jt_a && k_a >= 1 && k_a <= 800) begin
                if (hs_a == 1'b0) hs_cnt_a++;
                if (!von_a)       blank_cnt_a++;
            end
            if (ls_a) begin ls_k_a.push_back(k_a); ls_e_a.push_back(e_a); end
            if (jt_b && k_b >= 1 && k_b <= B_HT * B_VT && vs_b == 1'b1) vs_cnt_b++;
            if (fs_b) fs_k_b.push_back(k_b);
        end
    endtask

    // Assert reset mid-cycle (away from the edge) and check at once.
    task automatic reset_a();
        #2 rst_a_n = 1'b0;
        e_a = 0; k_a = 0; jt_a = 0;
        #1 check("rstA_now", {4'd0, obs_a}, {4'd0, exp_a()});
    endtask
    task automatic reset_b();
        #2 rst_b_n = 1'b0;
        e_b = 0; k_b = 0; jt_b = 0;
        #1 check("rstB_now", {4'd0, obs_b}, {4'd0, exp_b()});
    endtask

    initial begin
        // Reset state
        repeat (3) cyc();
        #2;
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;

        // First line of A, first two frames of B
        stats_en = 1;
        repeat ((B_HT * B_VT + 20) * CLK_PER_TICK) cyc();
        stats_en = 0;

        check("hsync_lo_ticks_A", 32'(hs_cnt_a), 32'd96);
        check("blank_ticks_A",    32'(blank_cnt_a), 32'd160);
        check("vsync_hi_ticks_B", 32'(vs_cnt_b), 32'(B_VS * B_HT));
        if (ls_k_a.size() >= 2) begin
            check("line_start_first_A", 32'(ls_k_a[0]), 32'd1);
            check("line_period_ticks_A", 32'(ls_k_a[1] - ls_k_a[0]), 32'd800);
            check("line_period_clks_A", 32'(ls_e_a[1] - ls_e_a[0]), 32'(800 * CLK_PER_TICK));
        end else check("line_start_count_A", 32'(ls_k_a.size()), 32'd2);
        if (fs_k_b.size() >= 2) begin
            check("frame_start_first_B", 32'(fs_k_b[0]), 32'd1);
            check("frame_period_B", 32'(fs_k_b[1] - fs_k_b[0]), 32'(B_HT * B_VT));
        end else check("frame_start_count_B", 32'(fs_k_b.size()), 32'd2);

        // Random mid-frame resets on either instance
        for (int it = 0; it < 4; it++) begin
            int r, hold;
            bit sel;
            r    = $urandom_range(20, 2500);
            hold = $urandom_range(1, 4);
            sel  = 1'($urandom_range(0, 1));
            repeat (r) cyc();
            if (sel) reset_a(); else reset_b();
            repeat (hold) cyc();
            #2;
            if (sel) rst_a_n = 1'b1; else rst_b_n = 1'b1;
            repeat ((B_HT * B_VT + 10) * CLK_PER_TICK) cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_vga_timing
`default_nettype wire
